mptr_bank: RTL and testbench
============================

# mptr_bank

Parametrised bank of memory pointer registers, successor to the single 16-bit memory pointer. Holds NPTR independent address pointers, each with a stored signed offset and a sticky wrap flag. Each pointer supports four access modes: plain, post-increment, pre-decrement and offset-add. It drives the shared tri-state address and data buses of the datapath and sits beside the register file, feeding the memory address path.

## Interface
Parameters:
- WIDTH, 16: pointer and bus width. Must satisfy WIDTH >= OFFW and WIDTH >= 4.
- OFFW, 12: offset width, two's complement.
- NPTR, 4: number of pointers.
- SELW, 2: pointer select width. Must satisfy 2**SELW >= NPTR.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- sel  input  SELW  pointer addressed by every operation this cycle. Values >= NPTR: reads float, writes ignored.
- din  input  WIDTH  write data.
- offsetin  input  OFFW  new offset, captured on an offset-add access.
- write  input  1  load data[sel] <= din.
- writeu  input  1  load data[sel][WIDTH-1:WIDTH-4] <= din[3:0].
- mode  input  2  access mode: 00 plain, 01 post-inc, 10 pre-dec, 11 offset-add.
- read_abus  input  1  drive selected pointer (mode-adjusted) onto abus_out and perform the mode update.
- read_abusplus  input  1  drive data[sel]+1 onto abus_out; no state change.
- read_dbus  input  1  drive data[sel] onto dbus_out.
- abus_out  output  WIDTH  tri-state address bus.
- dbus_out  output  WIDTH  tri-state data bus.
- wrap_out  output  1  sticky wrap flag of pointer sel.

## Operation
**State per pointer i:** data[i] (WIDTH bits), offset[i] (OFFW bits), wrap[i] (1 bit).

**abus_out (combinational):**
- read_abus=1: mode 00, 01 and 11 drive data[sel]; mode 10 drives data[sel]-1.
- read_abusplus=1 with read_abus=0: drives data[sel]+1.
- read_abus and read_abusplus both high: read_abus wins. Never two drivers.
- Otherwise: all Z.

**dbus_out:** data[sel] when read_dbus=1, else Z.

**wrap_out:** wrap[sel]. Outputs 0 when sel >= NPTR.

**Update priority at the clock edge (selected pointer only):**
1. write: data <= din; offset <= 0; wrap <= 0.
2. else writeu: upper 4 bits <= din[3:0]; lower bits held; offset <= 0; wrap <= 0.
3. else read_abus, by mode:
   - 00: no change.
   - 01: data <= data+1.
   - 10: data <= data-1.
   - 11: data <= data + sext(offset); offset <= offsetin. The offset applied is the one stored by the previous offset-add, not offsetin.
4. else: hold.

**Arithmetic:**
- All sums are modulo 2**WIDTH.
- sext replicates offset[OFFW-1] into the upper WIDTH-OFFW bits.
- wrap <= 1 on carry-out of the increment.
- wrap <= 1 on borrow out of the decrement.
- wrap <= 1 on a signed offset-add whose unsigned result crosses the 0 / 2**WIDTH-1 boundary:
  - positive offset and result < old value, or
  - negative offset and result > old value.
- wrap is sticky; only write, writeu or reset clear it.
- Non-selected pointers never change.

## Timing
- **Reset asserted (reset=0):** immediately, without waiting for clk, all data, offset and wrap go to 0. Buses still follow the read enables, so a read during reset drives 0. Asserting reset mid-operation discards any pending update.
- **Reset release:** first state update occurs on the first rising clk with reset=1.
- **Bus outputs:** zero-cycle combinational from sel, mode, read enables and current state. The address driven in a cycle uses pre-update state: post-increment returns the old value, and pre-decrement returns the value that is also stored at the edge.
- **State latency:** updates visible on the buses one cycle after the edge.
- **Back-to-back accesses:** read_abus held high for N cycles on one pointer in mode 01 produces N consecutive addresses.
- **Same cycle:** write and read_dbus in the same cycle drive the old value; the new value appears the next cycle.

## Test plan
- **Reset:** pulse reset=0 mid-cycle after loading data[1]=16'h1234 -> data[1] reads 16'h0000 before the next clk; wrap_out=0; abus_out=Z with no reads.
- **Offset-add chain:** write data[2]=16'h1000. read_abus mode 11 with offsetin=12'h010 -> abus 16'h1000. Again with offsetin=12'hFF0 -> abus 16'h1000 (stored offset 0 applied), data becomes 16'h1010. Third access -> abus 16'h1010, then data 16'h1000 (offset -16).
- **Post-inc / pre-dec:** data[0]=16'hFFFF, mode 01 read_abus -> abus 16'hFFFF, next data 16'h0000, wrap_out=1. Then writeu din=4'hA -> data 16'hA000, wrap_out=0. Mode 10 on data 16'h0000 -> abus 16'hFFFF, wrap_out=1.
- **Bus arbitration:** read_abus and read_abusplus both high with data=16'h0040, mode 00 -> abus 16'h0040. read_abusplus alone -> 16'h0041, no state change. read_dbus -> dbus 16'h0040.
- **Priority and isolation:** write and read_abus mode 01 in the same cycle on sel=3, din=16'h0500 -> data[3]=16'h0500, no increment. Pointers 0-2 unchanged.
- **Out-of-range select (NPTR=3, sel=3):** write is ignored; abus_out and dbus_out stay Z.

Source files
------------

// File: rtl/mptr_bank.sv
// Bank of NPTR address pointers with per-pointer signed offset and sticky wrap flag.
// One cell per pointer; the top muxes the selected cell onto the shared tri-state buses.

module mptr_cell #(
  parameter int WIDTH = 16,
  parameter int OFFW  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic             weu_i,
  input  logic             rd_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [OFFW-1:0]  offsetin_i,
  output logic [WIDTH-1:0] data_o,
  output logic             wrap_o
);
  logic [WIDTH-1:0] data_q, data_d, off_ext;
  logic [OFFW-1:0]  off_q, off_d;
  logic             wrap_q, wrap_d, carry;

  assign off_ext = WIDTH'($signed(off_q));

  always_comb begin
    data_d = data_q;
    off_d  = off_q;
    wrap_d = wrap_q;
    carry  = 1'b0;
    if (we_i) begin
      data_d = din_i;
      off_d  = '0;
      wrap_d = 1'b0;
    end else if (weu_i) begin
      data_d[WIDTH-1 -: 4] = din_i[3:0];
      off_d  = '0;
      wrap_d = 1'b0;
    end else if (rd_i) begin
      case (mode_i)
        2'b01: begin
          {carry, data_d} = {1'b0, data_q} + {{WIDTH{1'b0}}, 1'b1};
          if (carry) wrap_d = 1'b1;
        end
        2'b10: begin
          data_d = data_q - {{(WIDTH-1){1'b0}}, 1'b1};
          if (data_q == '0) wrap_d = 1'b1;
        end
        2'b11: begin
          // Applies the offset captured by the previous offset-add, then latches the new one.
          data_d = data_q + off_ext;
          off_d  = offsetin_i;
          if ((!off_q[OFFW-1] && data_d < data_q) || (off_q[OFFW-1] && data_d > data_q))
            wrap_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      off_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      data_q <= data_d;
      off_q  <= off_d;
      wrap_q <= wrap_d;
    end
  end

  assign data_o = data_q;
  assign wrap_o = wrap_q;
endmodule

module mptr_bank #(
  parameter int WIDTH = 16,
  parameter int OFFW  = 12,
  parameter int NPTR  = 4,
  parameter int SELW  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SELW-1:0]  sel,
  input  logic [WIDTH-1:0] din,
  input  logic [OFFW-1:0]  offsetin,
  input  logic             write,
  input  logic             writeu,
  input  logic [1:0]       mode,
  input  logic             read_abus,
  input  logic             read_abusplus,
  input  logic             read_dbus,
  output wire  [WIDTH-1:0] abus_out,
  output wire  [WIDTH-1:0] dbus_out,
  output logic             wrap_out
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [NPTR-1:0][WIDTH-1:0] ptr;
  logic [NPTR-1:0]            wrap;
  logic [WIDTH-1:0]           cur, abus_val;
  logic                       cur_wrap, sel_ok, abus_en;

  for (genvar g = 0; g < NPTR; g++) begin : g_ptr
    logic hit;
    assign hit = (sel == SELW'(g));
    mptr_cell #(.WIDTH(WIDTH), .OFFW(OFFW)) u_cell (
      .clk       (clk),
      .rst_n     (reset),
      .we_i      (hit & write),
      .weu_i     (hit & writeu),
      .rd_i      (hit & read_abus),
      .mode_i    (mode),
      .din_i     (din),
      .offsetin_i(offsetin),
      .data_o    (ptr[g]),
      .wrap_o    (wrap[g])
    );
  end

  // Out-of-range selects match no cell, leaving sel_ok low so the buses float.
  always_comb begin
    cur      = '0;
    cur_wrap = 1'b0;
    sel_ok   = 1'b0;
    for (int i = 0; i < NPTR; i++) begin
      if (sel == SELW'(i)) begin
        cur      = ptr[i];
        cur_wrap = wrap[i];
        sel_ok   = 1'b1;
      end
    end
  end

  always_comb begin
    abus_en  = sel_ok & (read_abus | read_abusplus);
    abus_val = cur + ONE;
    if (read_abus) abus_val = (mode == 2'b10) ? cur - ONE : cur;
  end

  assign abus_out = abus_en ? abus_val : {WIDTH{1'bz}};
  assign dbus_out = (sel_ok & read_dbus) ? cur : {WIDTH{1'bz}};
  assign wrap_out = cur_wrap;
endmodule

// File: tb/tb_mptr_bank.sv
// Bench for mptr_bank: directed scenarios plus randomized traffic against an integer reference model.

module tb_mptr_bank;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel, mode;
  logic [15:0] din;
  logic [11:0] offsetin;
  logic        write, writeu, read_abus, read_abusplus, read_dbus;
  wire  [15:0] abus, dbus, abus3, dbus3;
  logic        wrap, wrap3;

  int checks = 0, errors = 0;
  int m_data[4], m_off[4];
  bit m_wrap[4];

  always #5 clk = ~clk;

  // Floating buses are pulled high so an undriven bus is observable.
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (abus[g]);
    pullup (dbus[g]);
    pullup (abus3[g]);
    pullup (dbus3[g]);
  end

  mptr_bank dut (
    .clk(clk), .reset(reset), .sel(sel), .din(din), .offsetin(offsetin),
    .write(write), .writeu(writeu), .mode(mode), .read_abus(read_abus),
    .read_abusplus(read_abusplus), .read_dbus(read_dbus),
    .abus_out(abus), .dbus_out(dbus), .wrap_out(wrap)
  );

  mptr_bank #(.NPTR(3)) dut3 (
    .clk(clk), .reset(reset), .sel(sel), .din(din), .offsetin(offsetin),
    .write(write), .writeu(writeu), .mode(mode), .read_abus(read_abus),
    .read_abusplus(read_abusplus), .read_dbus(read_dbus),
    .abus_out(abus3), .dbus_out(dbus3), .wrap_out(wrap3)
  );

  function automatic bit floats(logic [15:0] v);
    return (v === 16'hFFFF) || (v === 16'hzzzz);
  endfunction

  task automatic idle();
    write = 0; writeu = 0; read_abus = 0; read_abusplus = 0; read_dbus = 0;
    mode = 0; din = 0; offsetin = 0;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin m_data[i] = 0; m_off[i] = 0; m_wrap[i] = 0; end
  endfunction

  function automatic void model_edge();
    int s = int'(sel);
    int r, o;
    if (write) begin
      m_data[s] = int'(din); m_off[s] = 0; m_wrap[s] = 0;
    end else if (writeu) begin
      m_data[s] = int'(din[3:0]) * 4096 + (m_data[s] % 4096); m_off[s] = 0; m_wrap[s] = 0;
    end else if (read_abus) begin
      r = m_data[s];
      if (mode == 2'd1) r = r + 1;
      else if (mode == 2'd2) r = r - 1;
      else if (mode == 2'd3) begin
        o = (m_off[s] >= 2048) ? m_off[s] - 4096 : m_off[s];
        r = r + o;
        m_off[s] = int'(offsetin);
      end
      if (r < 0 || r > 65535) m_wrap[s] = 1;
      m_data[s] = (r + 65536) % 65536;
    end
  endfunction

  function automatic int exp_abus();
    int d = m_data[int'(sel)];
    if (read_abus) return (mode == 2'd2) ? (d + 65535) % 65536 : d;
    if (read_abusplus) return (d + 1) % 65536;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 0; idle(); sel = 0; model_reset();
    #1;
    checks++; if (!floats(abus)) begin errors++; $display("FAIL rst_abus_z got %h exp Z", abus); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL rst_wrap got %b exp 0", wrap); end
    reset = 1;
    step();
    sel = 1; write = 1; din = 16'h1234;
    step();
    idle(); read_dbus = 1; #1;
    checks++; if (dbus !== 16'h1234) begin errors++; $display("FAIL rst_load got %h exp 1234", dbus); end
    reset = 0; model_reset(); #1;
    checks++; if (dbus !== 16'h0000) begin errors++; $display("FAIL rst_async got %h exp 0000", dbus); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL rst_wrap2 got %b exp 0", wrap); end
    read_dbus = 0; #1;
    checks++; if (!floats(abus) || !floats(dbus)) begin errors++; $display("FAIL rst_float got a=%h d=%h exp Z", abus, dbus); end
    reset = 1;
    step();
  endtask

  task automatic test_offset_chain();
    idle(); sel = 2; write = 1; din = 16'h1000;
    step();
    idle(); read_abus = 1; mode = 2'd3; offsetin = 12'h010; #1;
    checks++; if (abus !== 16'h1000) begin errors++; $display("FAIL offs_1 got %h exp 1000", abus); end
    step();
    offsetin = 12'hFF0; #1;
    checks++; if (abus !== 16'h1000) begin errors++; $display("FAIL offs_2 got %h exp 1000", abus); end
    step();
    offsetin = 12'h000; #1;
    checks++; if (abus !== 16'h1010) begin errors++; $display("FAIL offs_3 got %h exp 1010", abus); end
    step();
    idle(); read_dbus = 1; #1;
    checks++; if (dbus !== 16'h1000) begin errors++; $display("FAIL offs_data got %h exp 1000", dbus); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL offs_wrap got %b exp 0", wrap); end
  endtask

  task automatic test_postinc_predec();
    idle(); sel = 0; write = 1; din = 16'hFFFF;
    step();
    idle(); read_abus = 1; mode = 2'd1; #1;
    checks++; if (abus !== 16'hFFFF) begin errors++; $display("FAIL inc_abus got %h exp FFFF", abus); end
    step();
    idle(); read_dbus = 1; #1;
    checks++; if (dbus !== 16'h0000 || wrap !== 1'b1) begin errors++; $display("FAIL inc_wrap got %h/%b exp 0000/1", dbus, wrap); end
    idle(); writeu = 1; din = 16'h000A;
    step();
    idle(); read_dbus = 1; #1;
    checks++; if (dbus !== 16'hA000 || wrap !== 1'b0) begin errors++; $display("FAIL writeu got %h/%b exp A000/0", dbus, wrap); end
    idle(); write = 1; din = 16'h0000;
    step();
    idle(); read_abus = 1; mode = 2'd2; #1;
    checks++; if (abus !== 16'hFFFF) begin errors++; $display("FAIL dec_abus got %h exp FFFF", abus); end
    step();
    idle(); read_dbus = 1; #1;
    checks++; if (dbus !== 16'hFFFF || wrap !== 1'b1) begin errors++; $display("FAIL dec_wrap got %h/%b exp FFFF/1", dbus, wrap); end
  endtask

  task automatic test_bus_arb();
    idle(); sel = 1; write = 1; din = 16'h0040;
    step();
    idle(); read_abus = 1; read_abusplus = 1; #1;
    checks++; if (abus !== 16'h0040) begin errors++; $display("FAIL arb_both got %h exp 0040", abus); end
    step();
    read_abus = 0; #1;
    checks++; if (abus !== 16'h0041) begin errors++; $display("FAIL arb_plus got %h exp 0041", abus); end
    step();
    idle(); read_dbus = 1; #1;
    checks++; if (dbus !== 16'h0040) begin errors++; $display("FAIL arb_dbus got %h exp 0040", dbus); end
    write = 1; din = 16'h0777; #1;
    checks++; if (dbus !== 16'h0040) begin errors++; $display("FAIL same_cyc_old got %h exp 0040", dbus); end
    step();
    write = 0; #1;
    checks++; if (dbus !== 16'h0777) begin errors++; $display("FAIL same_cyc_new got %h exp 0777", dbus); end
  endtask

  task automatic test_priority();
    int snap[3];
    for (int i = 0; i < 3; i++) snap[i] = m_data[i];
    idle(); sel = 3; write = 1; din = 16'h0500; read_abus = 1; mode = 2'd1;
    step();
    idle(); read_dbus = 1; #1;
    checks++; if (dbus !== 16'h0500) begin errors++; $display("FAIL prio_wr got %h exp 0500", dbus); end
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i); #1;
      checks++; if (dbus !== 16'(snap[i])) begin errors++; $display("FAIL iso_p%0d got %h exp %h", i, dbus, 16'(snap[i])); end
    end
  endtask

  task automatic test_oor();
    idle(); sel = 3; write = 1; din = 16'h2222; read_abus = 1; read_dbus = 1; #1;
    checks++; if (!floats(abus3) || !floats(dbus3)) begin errors++; $display("FAIL oor_float got a=%h d=%h exp Z", abus3, dbus3); end
    checks++; if (wrap3 !== 1'b0) begin errors++; $display("FAIL oor_wrap got %b exp 0", wrap3); end
    step();
    idle(); read_dbus = 1;
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i); #1;
      checks++; if (dbus3 !== 16'(m_data[i])) begin errors++; $display("FAIL oor_iso_p%0d got %h exp %h", i, dbus3, 16'(m_data[i])); end
    end
  endtask

  task automatic test_random();
    int ea, nerr;
    nerr = 0;
    for (int n = 0; n < 400; n++) begin
      idle();
      sel = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: begin write = 1; din = (n % 3 == 0) ? 16'hFFFE : 16'($urandom); end
        1: begin writeu = 1; din = 16'($urandom); end
        default: ;
      endcase
      read_abus = ($urandom_range(0, 3) != 0);
      read_abusplus = $urandom_range(0, 1) != 0;
      read_dbus = $urandom_range(0, 1) != 0;
      mode = 2'($urandom);
      offsetin = 12'($urandom);
      #1;
      ea = exp_abus();
      checks++;
      if (ea < 0 ? !floats(abus) : (abus !== 16'(ea))) begin
        errors++;
        if (nerr++ < 10) $display("FAIL rnd_abus n=%0d got %h exp %0d", n, abus, ea);
      end
      checks++;
      if (read_dbus ? (dbus !== 16'(m_data[int'(sel)])) : !floats(dbus)) begin
        errors++;
        if (nerr++ < 10) $display("FAIL rnd_dbus n=%0d got %h exp %h", n, dbus, 16'(m_data[int'(sel)]));
      end
      checks++;
      if (wrap !== m_wrap[int'(sel)]) begin
        errors++;
        if (nerr++ < 10) $display("FAIL rnd_wrap n=%0d got %b exp %b", n, wrap, m_wrap[int'(sel)]);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_offset_chain();
    test_postinc_predec();
    test_bus_arb();
    test_priority();
    test_oor();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
